usb_rx: RTL and testbench

- Receive-side bit-to-byte stage that sits directly downstream of usb_cdr. It consumes the recovered line level q, the bit strobe en, and the eop/se0 flags.
- Per bit it does NRZI decoding, SYNC detection, bit unstuffing and LSB-first byte assembly.
- It presents bytes to the packet layer with a UTMI-like active/valid/error handshake.

---
 rtl/usb_rx_pkg.sv | 31 +++
 rtl/usb_nrzi_unstuff.sv | 68 ++++++
 rtl/usb_rx.sv | 183 ++++++++++++++++++
 tb/tb_usb_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive bit-to-byte stage.
package usb_rx_pkg;

    localparam int unsigned STUFF_LIMIT  = 6;
    localparam int unsigned BYTE_BITS    = 8;
    localparam int unsigned ONES_W       = 3;
    localparam int unsigned BIT_CNT_W    = $clog2(BYTE_BITS);
    localparam int unsigned ZERO_CNT_W   = 3;
    localparam int unsigned ZERO_CNT_MAX = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } usb_rx_state_t;

    // Per-clk view of the usb_cdr outputs feeding this stage.
    typedef struct packed {
        logic q;
        logic en;
        logic eop;
        logic se0;
    } d_port_t;

    // Increment that sticks at the counter's maximum value.
    function automatic logic [ZERO_CNT_W-1:0] sat_inc(input logic [ZERO_CNT_W-1:0] v);
        return (v == ZERO_CNT_W'(ZERO_CNT_MAX)) ? v : v + ZERO_CNT_W'(1);
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and run-of-ones tracker; flags stuff bits and stuff violations.
module usb_nrzi_unstuff
    import usb_rx_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  d_port_t line_i,
    input  logic    clr_i,
    input  logic    load_i,
    input  logic    count_en_i,
    output logic    bit_en_c_o,
    output logic    bit_c_o,
    output logic    stuff_drop_c_o,
    output logic    stuff_err_c_o
);

    logic              prev_q_q, prev_q_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              bit_ev;
    logic              nrzi_bit;
    logic              at_limit;

    // A bit is only sampled on a strobe with a valid line and no eop.
    assign bit_ev   = line_i.en & ~line_i.se0 & ~line_i.eop;
    assign nrzi_bit = (line_i.q == prev_q_q);
    assign at_limit = (ones_q == ONES_W'(STUFF_LIMIT));

    assign bit_en_c_o     = bit_ev;
    assign bit_c_o        = nrzi_bit;
    assign stuff_drop_c_o = bit_ev & count_en_i & at_limit & ~nrzi_bit;
    assign stuff_err_c_o  = bit_ev & count_en_i & at_limit &  nrzi_bit;

    // Next line reference level and ones-run length.
    always_comb begin
        prev_q_d = prev_q_q;
        ones_d   = ones_q;

        if (line_i.eop) begin
            prev_q_d = 1'b1;
        end else if (bit_ev) begin
            prev_q_d = line_i.q;
        end

        if (clr_i) begin
            ones_d = '0;
        end else if (load_i) begin
            ones_d = ONES_W'(1);
        end else if (bit_ev && count_en_i) begin
            if (at_limit) begin
                ones_d = nrzi_bit ? ones_q : '0;
            end else begin
                ones_d = nrzi_bit ? ones_q + ONES_W'(1) : '0;
            end
        end
    end

    // Decoder state registers; idle line level is J.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q_q <= 1'b1;
            ones_q   <= '0;
        end else begin
            prev_q_q <= prev_q_d;
            ones_q   <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx.sv
// USB receive stage: SYNC detection, unstuffed byte assembly, UTMI-style handshake.
module usb_rx
    import usb_rx_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 q,
    input  logic                 en,
    input  logic                 eop,
    input  logic                 se0,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_active,
    output logic                 rx_error
);

    d_port_t               line_s;
    usb_rx_state_t         state_q, state_d;
    logic [ZERO_CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_BITS-1:0]  shift_q, shift_d;
    logic [BYTE_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_active_q, rx_active_d;
    logic                  rx_error_q, rx_error_d;

    logic                  bit_en;
    logic                  bit_val;
    logic                  stuff_drop;
    logic                  stuff_err;
    logic                  sync_ok;
    logic                  dec_clr;
    logic                  dec_load;
    logic                  data_bit;

    assign line_s = '{q: q, en: en, eop: eop, se0: se0};

    assign sync_ok  = 32'(zero_cnt_q) >= SYNC_MIN_ZEROS;
    assign dec_clr  = (state_d == IDLE);
    assign dec_load = (state_q == SYNC) && (state_d == DATA);
    assign data_bit = (state_q == DATA) & bit_en & ~stuff_drop & ~stuff_err;

    usb_nrzi_unstuff u_nrzi_unstuff (
        .clk_i          (clk),
        .rst_i          (reset),
        .line_i         (line_s),
        .clr_i          (dec_clr),
        .load_i         (dec_load),
        .count_en_i     (state_q == DATA),
        .bit_en_c_o     (bit_en),
        .bit_c_o        (bit_val),
        .stuff_drop_c_o (stuff_drop),
        .stuff_err_c_o  (stuff_err)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; eop always returns to IDLE and wins over a bit.
    always_comb begin
        state_d = state_q;
        if (line_s.eop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_en && !bit_val) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (bit_en && bit_val) begin
                        state_d = sync_ok ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (stuff_err) begin
                        state_d = ABORT;
                    end
                end
                ABORT: begin
                    state_d = ABORT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM outputs and datapath next values.
    always_comb begin
        zero_cnt_d  = zero_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_error_d  = 1'b0;
        rx_active_d = (state_d == DATA) || (state_d == ABORT);

        if (line_s.eop) begin
            zero_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            // Only a packet cut inside a byte is reported; ABORT already flagged.
            if ((state_q == DATA) && (bit_cnt_q != '0)) begin
                rx_error_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_en && !bit_val) begin
                        zero_cnt_d = ZERO_CNT_W'(1);
                    end
                end
                SYNC: begin
                    if (bit_en) begin
                        if (!bit_val) begin
                            zero_cnt_d = sat_inc(zero_cnt_q);
                        end else begin
                            zero_cnt_d = '0;
                            bit_cnt_d  = '0;
                            shift_d    = '0;
                        end
                    end
                end
                DATA: begin
                    if (stuff_err) begin
                        rx_error_d = 1'b1;
                    end else if (data_bit) begin
                        shift_d   = {bit_val, shift_q[BYTE_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(BYTE_BITS - 1)) begin
                            rx_data_d  = {bit_val, shift_q[BYTE_BITS-1:1]};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                ABORT: begin
                    rx_error_d = 1'b0;
                end
                default: begin
                    zero_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            zero_cnt_q  <= zero_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx.sv
// Randomized packet-level bench for usb_rx with a byte/error scoreboard.
module tb_usb_rx;

    typedef logic [7:0] u8_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       q;
    logic       en;
    logic       eop;
    logic       se0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed activity, accumulated by the monitor.
    u8_t got_q[$];
    int  err_cnt     = 0;
    int  err_low_cnt = 0;
    int  both_cnt    = 0;
    int  active_cnt  = 0;

    int gap_lo = 4;
    int gap_hi = 4;

    always #5 clk = ~clk;

    usb_rx #(.SYNC_MIN_ZEROS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .q         (q),
        .en        (en),
        .eop       (eop),
        .se0       (se0),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_error  (rx_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample outputs on the inactive edge.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_error) begin
            err_cnt++;
            if (!rx_active) err_low_cnt++;
        end
        if (rx_valid && rx_error) both_cnt++;
        if (rx_active) active_cnt++;
    end

    // One bit period: hold the line, strobe en on the last clk of the period.
    task automatic drive_bit(input logic lvl, input logic s0, input logic ep);
        int gap;
        gap = int'($urandom_range(gap_hi, gap_lo));
        q   = lvl;
        se0 = s0;
        en  = 1'b0;
        eop = 1'b0;
        repeat (gap - 1) @(negedge clk);
        en  = 1'b1;
        eop = ep;
        @(negedge clk);
        en  = 1'b0;
        eop = 1'b0;
    endtask

    // Build the decoded bit stream, NRZI-encode it, then SE0 x2 and J with eop.
    task automatic send_packet(input int nzero, input u8_t pl[$], input int extra, input bit serr);
        bit   bits[$];
        int   ones;
        bit   b;
        logic lvl;
        for (int i = 0; i < nzero; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        ones = 1;
        for (int i = 0; i < pl.size() * 8 + extra; i++) begin
            if (i < pl.size() * 8) b = pl[i / 8][i % 8];
            else                   b = 1'($urandom_range(0, 1));
            bits.push_back(b);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                bits.push_back(1'b0);
                ones = 0;
            end
        end
        if (serr) repeat (7) bits.push_back(1'b1);
        lvl = 1'b1;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = ~lvl;
            drive_bit(lvl, 1'b0, 1'b0);
        end
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b1);
        repeat (3) drive_bit(1'b1, 1'b0, 1'b0);
    endtask

    // Send one packet and compare the observed bytes/errors against the expected outcome.
    task automatic run_pkt(input string tag, input int nzero, input u8_t pl[$],
                           input int extra, input bit serr);
        int  b0, e0, l0, x0, a0, nb;
        bit  accepted, exp_err, exp_low;
        u8_t exp_q[$];
        b0 = got_q.size();
        e0 = err_cnt;
        l0 = err_low_cnt;
        x0 = both_cnt;
        a0 = active_cnt;
        send_packet(nzero, pl, extra, serr);

        accepted = (nzero >= 3);
        exp_err  = accepted && (serr || (extra % 8 != 0));
        exp_low  = accepted && !serr && (extra % 8 != 0);
        if (accepted) exp_q = pl;

        nb = got_q.size() - b0;
        check_eq({tag, ".nbytes"}, 32'(nb), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < nb; i++)
            check_eq($sformatf("%s.byte%0d", tag, i), 32'(got_q[b0 + i]), 32'(exp_q[i]));
        check_eq({tag, ".errors"}, 32'(err_cnt - e0), 32'(exp_err));
        check_eq({tag, ".err_at_fall"}, 32'(err_low_cnt - l0), 32'(exp_low));
        check_eq({tag, ".valid_and_err"}, 32'(both_cnt - x0), 32'd0);
        check_eq({tag, ".active_seen"}, 32'(active_cnt != a0), 32'(accepted));
        check_eq({tag, ".active_end"}, 32'(rx_active), 32'd0);
        if (exp_q.size() > 0)
            check_eq({tag, ".data_hold"}, 32'(rx_data), 32'(exp_q[exp_q.size() - 1]));
    endtask

    initial begin
        u8_t  pl[$];
        bit   bits[$];
        logic lvl;
        int   kind;

        reset = 1'b1;
        q     = 1'b1;
        en    = 1'b0;
        eop   = 1'b0;
        se0   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.rx_data",   32'(rx_data),   32'd0);
        check_eq("rst.rx_valid",  32'(rx_valid),  32'd0);
        check_eq("rst.rx_active", 32'(rx_active), 32'd0);
        check_eq("rst.rx_error",  32'(rx_error),  32'd0);
        reset = 1'b0;
        repeat (3) drive_bit(1'b1, 1'b0, 1'b0);

        pl = {8'hA5};
        run_pkt("a5", 7, pl, 0, 1'b0);
        pl = {8'hFF, 8'h00};
        run_pkt("ff00", 7, pl, 0, 1'b0);
        pl = {};
        run_pkt("stuff_err", 7, pl, 0, 1'b1);
        pl = {8'h3C};
        run_pkt("partial", 7, pl, 3, 1'b0);
        pl = {};
        run_pkt("trunc_sync", 2, pl, 0, 1'b0);
        pl = {8'h81, 8'h7E};
        run_pkt("sync3", 3, pl, 0, 1'b0);
        pl = {8'h42};
        run_pkt("sync_sat", 10, pl, 0, 1'b0);

        // Random 64-bit payloads, alternating nominal and jittered bit timing.
        for (int p = 0; p < 16; p++) begin
            gap_lo = (p % 2 == 1) ? 3 : 4;
            gap_hi = (p % 2 == 1) ? 5 : 4;
            pl = {};
            for (int i = 0; i < 8; i++)
                pl.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            kind = int'($urandom_range(0, 3));
            run_pkt($sformatf("rnd%0d", p), int'($urandom_range(3, 8)), pl,
                    (kind == 2) ? int'($urandom_range(1, 7)) : 0, kind == 3);
        end
        gap_lo = 4;
        gap_hi = 4;

        // Reset in the middle of a byte, then a clean packet.
        bits = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        lvl = 1'b1;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = ~lvl;
            drive_bit(lvl, 1'b0, 1'b0);
        end
        check_eq("mid.rx_active", 32'(rx_active), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("async.rx_data",   32'(rx_data),   32'd0);
        check_eq("async.rx_valid",  32'(rx_valid),  32'd0);
        check_eq("async.rx_active", 32'(rx_active), 32'd0);
        check_eq("async.rx_error",  32'(rx_error),  32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) drive_bit(1'b1, 1'b0, 1'b0);
        pl = {8'h5A};
        run_pkt("post_rst", 7, pl, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
